// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request decode helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } lsu_state_e;

    // Illegal codes (and unsigned widths on a store) are reported as misaligned.
    function automatic logic lsu_misaligned(input logic store, input logic [2:0] funct3,
                                            input logic [1:0] ea_lo);
        logic mis;
        case (funct3)
            F3_B:    mis = 1'b0;
            F3_H:    mis = ea_lo[0];
            F3_W:    mis = (ea_lo != 2'b00);
            F3_BU:   mis = store;
            F3_HU:   mis = store | ea_lo[0];
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lsu_store_mask(input logic [2:0] funct3, input logic [1:0] ea_lo);
        logic [3:0] m;
        case (funct3)
            F3_B:    m = MASK_B << ea_lo;
            F3_H:    m = MASK_H << ea_lo;
            F3_W:    m = MASK_W;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lsu_store_data(input logic [2:0] funct3, input logic [31:0] sdata);
        logic [31:0] d;
        case (funct3)
            F3_B:    d = {4{sdata[7:0]}};
            F3_H:    d = {2{sdata[15:0]}};
            default: d = sdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a loaded word and sign/zero-extends it per funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_ldata,
    input  logic [1:0]  ea,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [15:0] lane;

    always_comb begin
        lane  = 16'(mem_ldata >> {ea, 3'b000});
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   rdata = {24'b0, lane[7:0]};
            F3_H:    rdata = {{16{lane[15]}}, lane[15:0]};
            F3_HU:   rdata = {16'b0, lane[15:0]};
            F3_W:    rdata = mem_ldata;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time through IDLE -> ISSUE -> RESP,
// with misaligned or illegal requests answered directly without a bus access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_base,
    input  logic [XLEN-1:0] req_offset,
    input  logic [XLEN-1:0] req_sdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic [4:0]      resp_rd,
    output logic            resp_misalign,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_sdata,
    output logic            mem_lenable,
    output logic [3:0]      mem_mask,
    input  logic [XLEN-1:0] mem_ldata
);

    lsu_state_e      state;
    logic [XLEN-1:0] ea;
    logic            acc_misalign;
    logic            store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] load_rdata;

    assign ea           = req_base + req_offset;
    assign acc_misalign = lsu_misaligned(req_store, req_funct3, ea[1:0]);
    assign req_ready    = (state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            resp_valid    <= 1'b0;
            resp_misalign <= 1'b0;
            resp_rd       <= '0;
            mem_addr      <= '0;
            mem_sdata     <= '0;
            mem_lenable   <= 1'b0;
            mem_mask      <= '0;
            store_q       <= 1'b0;
            funct3_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        mem_addr <= ea;
                        resp_rd  <= req_rd;
                        store_q  <= req_store;
                        funct3_q <= req_funct3;
                        if (acc_misalign) begin
                            state         <= ST_RESP;
                            resp_valid    <= 1'b1;
                            resp_misalign <= 1'b1;
                        end else begin
                            state         <= ST_ISSUE;
                            resp_misalign <= 1'b0;
                            mem_lenable   <= ~req_store;
                            mem_mask      <= req_store ? lsu_store_mask(req_funct3, ea[1:0]) : '0;
                            if (req_store) begin
                                mem_sdata <= lsu_store_data(req_funct3, req_sdata);
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    state       <= ST_RESP;
                    resp_valid  <= 1'b1;
                    mem_lenable <= 1'b0;
                    mem_mask    <= '0;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state         <= ST_IDLE;
                        resp_valid    <= 1'b0;
                        resp_misalign <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    lsu_load_align u_align (
        .mem_ldata (mem_ldata),
        .ea        (mem_addr[1:0]),
        .funct3    (funct3_q),
        .rdata     (load_rdata)
    );

    // Load data arrives one clock after ISSUE and the bus holds it, so the
    // response word is taken combinationally while sitting in RESP.
    assign resp_rdata = (state == ST_RESP && !resp_misalign && !store_q) ? load_rdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner cases plus random traffic against a
// byte-level reference memory and plain-arithmetic load/store rules.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base, req_offset, req_sdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_ready, resp_misalign;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [31:0] mem_addr, mem_sdata, mem_ldata;
    logic        mem_lenable;
    logic [3:0]  mem_mask;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        preload_en = 1'b0;
    logic [7:0]  preload_idx = '0;
    logic [31:0] preload_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_sdata(req_sdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_misalign(resp_misalign),
        .mem_addr(mem_addr), .mem_sdata(mem_sdata), .mem_lenable(mem_lenable),
        .mem_mask(mem_mask), .mem_ldata(mem_ldata)
    );

    // Data memory: one-clock read latency, read data held while mem_lenable is low.
    initial mem_ldata = '0;
    always @(posedge clk) begin : bus_model
        logic [31:0] w;
        if (preload_en) mem[preload_idx] <= preload_data;
        if (mem_lenable) mem_ldata <= mem[mem_addr[9:2]];
        if (mem_mask != 4'b0000) begin
            w = mem[mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) w[8*b +: 8] = mem_sdata[8*b +: 8];
            mem[mem_addr[9:2]] <= w;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic ref_misalign(input logic st, input logic [2:0] f3, input logic [31:0] ea);
        int nb = ref_size(f3);
        if (nb == 0) return 1'b1;
        if (st && f3[2]) return 1'b1;
        return (ea % nb) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] ea);
        int nb = ref_size(f3);
        int width = 8 * nb;
        logic [31:0] v;
        v = ref_mem[ea[9:2]] >> (8 * ea[1:0]);
        if (nb == 4) return v;
        v = v & ((32'd1 << width) - 32'd1);
        if (!f3[2] && v >= (32'd1 << (width - 1))) v = v - (32'd1 << width);
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] sd);
        logic [31:0] w = ref_mem[ea[9:2]];
        for (int i = 0; i < ref_size(f3); i++)
            w[8*(int'(ea[1:0]) + i) +: 8] = sd[8*i +: 8];
        ref_mem[ea[9:2]] = w;
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd,
                          input int unsigned stall);
        logic [31:0] ea, exp_rdata, exp_mask, exp_sdata;
        logic mis;
        int nb;
        ea  = base + off;
        nb  = ref_size(f3);
        mis = ref_misalign(st, f3, ea);
        exp_rdata = (!mis && !st) ? ref_load(f3, ea) : 32'd0;
        exp_mask  = (st && !mis) ? (((32'd1 << nb) - 32'd1) << ea[1:0]) : 32'd0;
        exp_sdata = (nb == 1) ? {24'd0, sd[7:0]} * 32'h01010101 :
                    (nb == 2) ? {16'd0, sd[15:0]} * 32'h00010001 : sd;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_base = base; req_offset = off; req_sdata = sd; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_sdata = $urandom; req_rd = 5'($urandom); req_funct3 = 3'($urandom);
        if (mis) begin
            check("mis_lenable", 32'(mem_lenable), 32'd0);
            check("mis_mask", 32'(mem_mask), 32'd0);
        end else begin
            check("issue_valid", 32'(resp_valid), 32'd0);
            check("issue_ready", 32'(req_ready), 32'd0);
            check("issue_addr", mem_addr, ea);
            check("issue_lenable", 32'(mem_lenable), 32'(!st));
            check("issue_mask", 32'(mem_mask), exp_mask);
            if (st) begin
                check("issue_sdata", mem_sdata, exp_sdata);
                ref_store(f3, ea, sd);
            end
            @(posedge clk); #1;
        end
        for (int unsigned i = 0; i <= stall; i++) begin
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_rdata", resp_rdata, exp_rdata);
            check("resp_rd", 32'(resp_rd), 32'(rd));
            check("resp_misalign", 32'(resp_misalign), 32'(mis));
            check("resp_ready_low", 32'(req_ready), 32'd0);
            check("resp_bus_idle", {27'd0, mem_lenable, mem_mask}, 32'd0);
            if (i == stall) resp_ready = 1'b1;
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        check("post_valid", 32'(resp_valid), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
        if (st && !mis) check("mem_word", mem[ea[9:2]], ref_mem[ea[9:2]]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] swdata;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_base = '0; req_offset = '0; req_sdata = '0; req_rd = '0; resp_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            preload_en = 1'b1; preload_idx = 8'(i); preload_data = $urandom;
            ref_mem[i] = preload_data;
            @(posedge clk); #1;
        end
        preload_en = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_misalign", 32'(resp_misalign), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_rd", 32'(resp_rd), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_sdata", mem_sdata, 32'd0);
        check("rst_bus", {27'd0, mem_lenable, mem_mask}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(1'b0, 3'b010, 32'h100, 32'd4, 32'd0, 5'd7, 0);
        do_req(1'b1, 3'b000, 32'h203, 32'd0, 32'h000000A5, 5'd0, 0);
        do_req(1'b1, 3'b010, 32'h0, 32'h0, 32'h00800000, 5'd1, 0);
        do_req(1'b0, 3'b000, 32'h2, 32'h0, 32'd0, 5'd2, 0);
        do_req(1'b0, 3'b100, 32'h2, 32'h0, 32'd0, 5'd3, 0);
        do_req(1'b0, 3'b001, 32'h101, 32'h0, 32'd0, 5'd4, 0);
        do_req(1'b0, 3'b101, 32'h0, 32'h2, 32'd0, 5'd5, 3);
        do_req(1'b1, 3'b100, 32'h40, 32'h0, 32'h1234, 5'd6, 1);

        // Reset during ISSUE of a store must drop the write and the response.
        swdata = 32'hDEADBEEF;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_base = 32'h80; req_offset = 32'h0; req_sdata = swdata; req_rd = 5'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_mask_before", 32'(mem_mask), 32'hF);
        #2 rst = 1'b1;
        #1;
        check("abort_mask", 32'(mem_mask), 32'd0);
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        check("abort_mem", mem[8'h20], ref_mem[8'h20]);

        for (int n = 0; n < 150; n++) begin
            int off;
            off = int'($urandom_range(0, 32)) - 16;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(32, 960)), 32'(off), $urandom,
                   5'($urandom), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
